fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Single-clock synchronous FIFO that succeeds the basic sync FIFO.
- Keeps the cs/wr_en/rd_en interface.
- Adds an occupancy count, programmable almost-full and almost-empty flags, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Used as the general buffering element between producer/consumer blocks in the datapath.

Parameters:
- DATA_WIDTH, 32, width of data_in and data_out.
- FIFO_DEPTH, 8, number of entries; power of 2, at least 2.
- AFULL_THRESH, FIFO_DEPTH-2, almost_full is asserted when count >= this value.
- AEMPTY_THRESH, 2, almost_empty is asserted when count <= this value.
- FWFT, 0, read mode: 0 = standard registered read with 1-cycle latency; 1 = head word is presented on data_out while not empty.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select; when low, no push, no pop and no error pulses.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == FIFO_DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, range 0..FIFO_DEPTH.
- overflow  out  1  one-cycle pulse: write requested while full.
- underflow  out  1  one-cycle pulse: read requested while empty.

Behaviour:
- Reset (rst=1 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0; data_out goes to 0; overflow and underflow go to 0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents.
  - After reset: empty=1, almost_empty=1, full=0, almost_full=0.
- Push and pop conditions:
  - push = cs & wr_en & !full
  - pop = cs & rd_en & !empty
  - Both are evaluated on the pre-edge state.
- Push: mem[wr_ptr] <= data_in; wr_ptr increments modulo FIFO_DEPTH (wraps from FIFO_DEPTH-1 to 0).
- Pop: rd_ptr increments modulo FIFO_DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push+pop or on neither.
- Flags are combinational decodes of the registered count, so they update in the same cycle count changes.
- Simultaneous events:
  - Full with wr+rd: the pop is accepted, the write is rejected, overflow pulses, count goes to FIFO_DEPTH-1.
  - Empty with wr+rd: the push is accepted, the read is rejected, underflow pulses, count goes to 1.
  - Otherwise both are accepted and count is unchanged.
- overflow is registered high for exactly one cycle after an edge with cs & wr_en & full. underflow likewise for cs & rd_en & empty.
- Rejected operations do not modify storage, pointers or count.
- FWFT=0: on pop, data_out <= mem[rd_ptr], valid from the cycle after the pop edge. With no pop, data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] continuously; it is valid whenever empty=0 and don't-care when empty.
  - A pop advances to the next word.
  - The data_out reset value does not apply in this mode.
- Elaboration check: AFULL_THRESH <= FIFO_DEPTH and AEMPTY_THRESH < FIFO_DEPTH.

Decomposition:
- Shared package fifo_pkg holds:
  - the count-width function clog2(depth)+1;
  - the mode constants FWFT_OFF=0 and FWFT_ON=1.
- One sub-module, fifo_ram: a DATA_WIDTH x FIFO_DEPTH register array with a synchronous write port and an asynchronous read port.
- Pointers, count, flags and read-mode muxing live in the top level.

Test Plan:
All scenarios use DEPTH=8, AF=6, AE=2 unless noted.
1. Reset, then write 1, 10, 100, then read 4 times (FWFT=0) -> data_out = 1, 10, 100, each 1 cycle after its pop. The 4th read pulses underflow, data_out stays 100, count returns to 0.
2. Write 2**i for i=0..7 -> count 1..8. almost_full rises when count=6. full=1 at count=8. A 9th write pulses overflow and count stays 8. Then 8 reads return 1, 2, 4, ..., 128 in order.
3. Interleave write 2**i and read 16 times -> pointers wrap past 7. All data matches, count toggles 0↔1, no error pulses.
4. Fill to 8, then assert wr_en and rd_en together with data 77 -> the head word pops, 77 is not stored, overflow=1 for one cycle, count=7. On empty, wr+rd with 5 -> count=1, underflow=1, and 5 is read next.
5. FWFT=1: write 3, 4 -> data_out=3 while empty=0. A pop shows 4 in the same cycle count=1, with no extra latency.
6. Load 5 words, assert rst for 1 cycle -> count=0, empty=1, almost_empty=1, data_out=0. A subsequent write/read of 9 returns 9.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO: count width helper and read-mode constants.
package fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int unsigned count_width(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bus of the flagged FIFO: write/read requests, data and status.
interface fifo_sync_flags_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned CW = fifo_pkg::count_width(FIFO_DEPTH);

  logic                  cs;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cs, wr_en, rd_en, data_in,
    input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  cs, wr_en, rd_en, data_in,
    output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses and optional FWFT read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = FWFT_OFF
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_flags_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = count_width(FIFO_DEPTH);

  if (AFULL_THRESH > FIFO_DEPTH || AEMPTY_THRESH >= FIFO_DEPTH || FIFO_DEPTH < 2) begin : g_bad_cfg
    $error("fifo_sync_flags: illegal depth/threshold configuration");
  end

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  is_full;
  logic                  is_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign is_full  = (count == CW'(FIFO_DEPTH));
  assign is_empty = (count == '0);
  assign push     = bus.cs & bus.wr_en & ~is_full;
  assign pop      = bus.cs & bus.rd_en & ~is_empty;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

  // Pointers, occupancy and error pulses; rejected requests leave state untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= bus.cs & bus.wr_en & is_full;
      underflow <= bus.cs & bus.rd_en & is_empty;
    end
  end

  if (FWFT == FWFT_ON) begin : g_fwft
    assign bus.data_out = ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk) begin
      if (rst)      rd_data <= '0;
      else if (pop) rd_data <= ram_rdata;
    end

    assign bus.data_out = rd_data;
  end

  assign bus.count        = count;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (count >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count <= CW'(AEMPTY_THRESH));
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: table of per-cycle vectors on a standard-read FIFO plus FWFT and reset sequences.
module tb_fifo_sync_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) f0 ();
  fifo_sync_flags_if #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) f1 ();

  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(f0));
  fifo_sync_flags #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(f1));

  typedef struct {
    logic        cs;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic        dchk;
    logic [31:0] dout;
    logic [3:0]  cnt;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cs, logic wr, logic rd, logic [31:0] din,
                              logic dchk, logic [31:0] dout, logic [3:0] cnt,
                              logic ovf, logic udf);
    vec_t v;
    v.cs = cs; v.wr = wr; v.rd = rd; v.din = din; v.dchk = dchk;
    v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags for depth 8, almost_full at >=6, almost_empty at <=2: {empty, almost_empty, almost_full, full}.
  function automatic logic [3:0] exp_flags(input logic [3:0] cnt);
    return {cnt == 4'd0, cnt <= 4'd2, cnt >= 4'd6, cnt == 4'd8};
  endfunction

  task automatic chk_state0(input string tag, input logic [3:0] cnt, input logic ovf, input logic udf);
    chk({tag, " count"}, 32'(f0.count), 32'(cnt));
    chk({tag, " flags"}, 32'({f0.empty, f0.almost_empty, f0.almost_full, f0.full}), 32'(exp_flags(cnt)));
    chk({tag, " overflow"}, 32'(f0.overflow), 32'(ovf));
    chk({tag, " underflow"}, 32'(f0.underflow), 32'(udf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic cs, input logic wr, input logic rd, input logic [31:0] din);
    f0.cs = cs; f0.wr_en = wr; f0.rd_en = rd; f0.data_in = din;
  endtask

  task automatic drive1(input logic cs, input logic wr, input logic rd, input logic [31:0] din);
    f1.cs = cs; f1.wr_en = wr; f1.rd_en = rd; f1.data_in = din;
  endtask

  initial begin
    // Scenario 1: three writes, four reads, last read underflows.
    vecs.push_back(mk(1, 1, 0, 32'd1,   0, 32'd0,   4'd1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'd10,  0, 32'd0,   4'd2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'd100, 1, 32'd0,   4'd3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'd0,   1, 32'd1,   4'd2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'd0,   1, 32'd10,  4'd1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'd0,   1, 32'd100, 4'd0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'd0,   1, 32'd100, 4'd0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'd0,   1, 32'd100, 4'd0, 0, 0));
    // Scenario 2: fill with powers of two, overflow, drain in order.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 0, 32'd1 << i, 1, 32'd100, 4'(i + 1), 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'hdead, 1, 32'd100, 4'd8, 1, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 1, 32'd0, 1, 32'd1 << i, 4'(7 - i), 0, 0));
    // Scenario 4: simultaneous wr+rd when full and when empty, plus deselected request.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 0, 32'(11 + i), 1, 32'd128, 4'(i + 1), 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd77, 1, 32'd11, 4'd7, 1, 0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1, 0, 1, 32'd0, 1, 32'(12 + i), 4'(6 - i), 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'd99, 1, 32'd18, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'd5,  1, 32'd18, 4'd1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 32'd0,  1, 32'd5,  4'd0, 0, 0));
    // Scenario 3: interleaved write/read across pointer wrap.
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(1, 1, 0, 32'd1 << i, 0, 32'd0, 4'd1, 0, 0));
      vecs.push_back(mk(1, 0, 1, 32'd0, 1, 32'd1 << i, 4'd0, 0, 0));
    end

    drive0(0, 0, 0, 32'd0);
    drive1(0, 0, 0, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk_state0("reset", 4'd0, 0, 0);
    chk("reset data_out", f0.data_out, 32'd0);
    chk("reset fwft empty", 32'(f1.empty), 32'd1);

    foreach (vecs[k]) begin
      drive0(vecs[k].cs, vecs[k].wr, vecs[k].rd, vecs[k].din);
      tick();
      chk_state0($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].ovf, vecs[k].udf);
      if (vecs[k].dchk) chk($sformatf("vec%0d data_out", k), f0.data_out, vecs[k].dout);
    end

    // Scenario 6: reset with contents discards them, then normal operation resumes.
    for (int i = 0; i < 5; i++) begin
      drive0(1, 1, 0, 32'(20 + i));
      tick();
    end
    drive0(1, 0, 1, 32'd0);
    tick();
    chk("prerst data_out", f0.data_out, 32'd20);
    chk_state0("prerst", 4'd4, 0, 0);
    drive0(0, 0, 0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_state0("midrst", 4'd0, 0, 0);
    chk("midrst data_out", f0.data_out, 32'd0);
    drive0(1, 1, 0, 32'd9);
    tick();
    chk_state0("postrst wr", 4'd1, 0, 0);
    drive0(1, 0, 1, 32'd0);
    tick();
    chk("postrst data_out", f0.data_out, 32'd9);
    chk_state0("postrst rd", 4'd0, 0, 0);
    drive0(0, 0, 0, 32'd0);

    // Scenario 5: FWFT head word is visible without read latency.
    drive1(1, 1, 0, 32'd3);
    tick();
    chk("fwft w3 count", 32'(f1.count), 32'd1);
    chk("fwft w3 empty", 32'(f1.empty), 32'd0);
    chk("fwft w3 data_out", f1.data_out, 32'd3);
    drive1(1, 1, 0, 32'd4);
    tick();
    chk("fwft w4 count", 32'(f1.count), 32'd2);
    chk("fwft w4 data_out", f1.data_out, 32'd3);
    drive1(1, 0, 1, 32'd0);
    tick();
    chk("fwft pop1 count", 32'(f1.count), 32'd1);
    chk("fwft pop1 data_out", f1.data_out, 32'd4);
    tick();
    chk("fwft pop2 count", 32'(f1.count), 32'd0);
    chk("fwft pop2 empty", 32'(f1.empty), 32'd1);
    chk("fwft pop2 underflow", 32'(f1.underflow), 32'd0);
    tick();
    chk("fwft extra underflow", 32'(f1.underflow), 32'd1);
    drive1(0, 0, 0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
